// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the RV32I memory responder.
// Holds access-size and FSM encodings plus the alignment check.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Illegal sizes are flagged separately by the caller.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      HALF:    return off[0];
      WORD:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core and the memory responder.
// The master is the core side; the slave is the responder.
interface mem_responder_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDRSIZE+1:0]   req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [WIDTH-1:0]      req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_lane_align.sv
// Byte-lane steering for a little-endian 32-bit word memory.
// Store path builds the write word and byte enables; load path extracts and extends.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]      wdata,
  input  size_e                 size,
  input  logic [1:0]            offset,
  output logic [WIDTH-1:0]      wword,
  output logic [WORD_BYTES-1:0] wbe,
  input  logic [WIDTH-1:0]      rword,
  input  logic                  unsigned_ld,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] shifted;

  // Replicate narrow store data across the word so any lane can pick it up.
  always_comb begin
    wword = '0;
    wbe   = '0;
    case (size)
      BYTE: begin
        wword = {4{wdata[7:0]}};
        wbe   = 4'b0001 << offset;
      end
      HALF: begin
        wword = {2{wdata[15:0]}};
        wbe   = offset[1] ? 4'b1100 : 4'b0011;
      end
      WORD: begin
        wword = wdata;
        wbe   = 4'b1111;
      end
      default: begin
        wword = '0;
        wbe   = '0;
      end
    endcase
  end

  always_comb begin
    shifted = rword >> {offset, 3'b000};
    rdata   = '0;
    case (size)
      BYTE:    rdata = unsigned_ld ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    rdata = unsigned_ld ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      WORD:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port data/instruction memory responder with configurable wait states.
// One request at a time; the response is held until the requester accepts it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDRSIZE    = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam int         DEPTH     = 1 << ADDRSIZE;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  do_access;

  logic                  lat_we, lat_uns;
  logic [ADDRSIZE+1:0]   lat_addr;
  size_e                 lat_size;
  logic [WIDTH-1:0]      lat_wdata;

  logic                  acc_we, acc_uns, acc_err;
  logic [ADDRSIZE+1:0]   acc_addr;
  size_e                 acc_size;
  logic [WIDTH-1:0]      acc_wdata;
  logic [ADDRSIZE-1:0]   acc_idx;

  logic [WIDTH-1:0]      mem [0:DEPTH-1];
  logic [WIDTH-1:0]      rword, wword, ld_data;
  logic [WORD_BYTES-1:0] wbe;
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;

  // With zero wait states the access happens on the accepting edge, so the
  // live bus fields are used instead of the (not yet loaded) latch.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_size  = size_e'(bus.req_size);
      acc_uns   = bus.req_unsigned;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_size  = lat_size;
      acc_uns   = lat_uns;
      acc_wdata = lat_wdata;
    end
    acc_idx = acc_addr[ADDRSIZE+1:2];
    acc_err = (acc_size == ILLEGAL) || is_misaligned(acc_size, acc_addr[1:0]);
  end

  // WAIT lasts WAIT_CYCLES+1 cycles: the wait states plus the access cycle,
  // so the response appears WAIT_CYCLES+1 edges after the accept.
  always_comb begin
    state_d   = state_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            do_access = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        cnt_q <= WAIT_LOAD;
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req_valid) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_size  <= size_e'(bus.req_size);
      lat_uns   <= bus.req_unsigned;
      lat_wdata <= bus.req_wdata;
    end
  end

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .wdata       (acc_wdata),
    .size        (acc_size),
    .offset      (acc_addr[1:0]),
    .wword       (wword),
    .wbe         (wbe),
    .rword       (rword),
    .unsigned_ld (acc_uns),
    .rdata       (ld_data)
  );

  assign rword = mem[acc_idx];

  // The array is not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_err) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wbe[i]) mem[acc_idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      err_q   <= acc_err;
      rdata_q <= (acc_we || acc_err) ? '0 : ld_data;
    end else if (state_q == RESP && bus.rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with two and zero wait states.
// Expected values are hand-computed from little-endian lane rules.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_responder_if #(.WIDTH(32), .ADDRSIZE(12)) bus  ();
  mem_responder_if #(.WIDTH(32), .ADDRSIZE(12)) bus0 ();

  mem_responder #(.WIDTH(32), .ADDRSIZE(12), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.WIDTH(32), .ADDRSIZE(12), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the two-wait-state responder; called #1 after an edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [13:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    checkOutput({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_addr     = 14'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_wdata    = $urandom;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd3);
    checkOutput({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
    checkOutput({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;
    bus.req_size  = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
    bus0.req_size  = 2'b00; bus0.req_unsigned = 1'b0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;

    @(posedge clk); #1;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset rsp_err",   32'(bus.rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("st word 010",    1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus("ld word 010",    1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    applyStimulus("ld byte 013 s",  1'b0, 14'h013, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0);
    applyStimulus("ld byte 013 u",  1'b0, 14'h013, 2'b00, 1'b1, 32'h0, 32'h000000DE, 1'b0);
    applyStimulus("ld half 012 s",  1'b0, 14'h012, 2'b01, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0);
    applyStimulus("ld half 010 u",  1'b0, 14'h010, 2'b01, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);
    applyStimulus("st byte 011",    1'b1, 14'h011, 2'b00, 1'b0, 32'hAAAAAA55, 32'h0, 1'b0);
    applyStimulus("ld word merged", 1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0);

    applyStimulus("st word 020",    1'b1, 14'h020, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0);
    applyStimulus("st half 021",    1'b1, 14'h021, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1);
    applyStimulus("ld word 020",    1'b0, 14'h020, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0);
    applyStimulus("ld word 022",    1'b0, 14'h022, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus("ld size11 024",  1'b0, 14'h024, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus("st size11 020",  1'b1, 14'h020, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    applyStimulus("ld word 020 b",  1'b0, 14'h020, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0);

    // Backpressure: response held for five cycles with rsp_ready low.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 14'h010;
    bus.req_size  = 2'b10; bus.req_unsigned = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp rdata", bus.rsp_rdata, 32'hDEAD55EF);
      checkOutput("bp valid/ready/err", {29'd0, bus.rsp_valid, bus.req_ready, bus.rsp_err}, 32'b100);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("bp req_ready after accept", 32'(bus.req_ready), 32'd1);
    checkOutput("bp rsp_valid after accept", 32'(bus.rsp_valid), 32'd0);

    // Reset during WAIT of a store must drop the write.
    applyStimulus("st word 030",    1'b1, 14'h030, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 14'h030;
    bus.req_size  = 2'b10; bus.req_wdata = 32'h11111111;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst wait req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst wait rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst wait rsp_err",   32'(bus.rsp_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst wait no rsp", 32'(bus.rsp_valid), 32'd0);
    applyStimulus("ld word 030",    1'b0, 14'h030, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during RESP must clear the held response.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 14'h030; bus.req_size = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("rst resp pre rdata", bus.rsp_rdata, 32'hCAFEF00D);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst resp req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst resp rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst resp rsp_err",   32'(bus.rsp_err), 32'd0);

    // Zero-wait-state build.
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 14'h040;
    bus0.req_size  = 2'b10; bus0.req_wdata = 32'hA5A5C3C3;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    checkOutput("w0 st rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    checkOutput("w0 st req_ready", 32'(bus0.req_ready), 32'd0);
    checkOutput("w0 st err",       32'(bus0.rsp_err), 32'd0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    checkOutput("w0 st idle", 32'(bus0.req_ready), 32'd1);

    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 14'h040;
    bus0.req_size  = 2'b10; bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    checkOutput("w0 ld rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    checkOutput("w0 ld rdata",     bus0.rsp_rdata, 32'hA5A5C3C3);
    @(posedge clk); #1;
    checkOutput("w0 ld idle", 32'(bus0.req_ready), 32'd1);
    checkOutput("w0 ld rsp done", 32'(bus0.rsp_valid), 32'd0);

    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 14'h042;
    bus0.req_size  = 2'b00; bus0.req_unsigned = 1'b0;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    checkOutput("w0 ld byte 042", bus0.rsp_rdata, 32'hFFFFFFA5);
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_addr = 14'h041; bus0.req_size = 2'b01;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    checkOutput("w0 ld half 041 err", {31'd0, bus0.rsp_err}, 32'd1);
    checkOutput("w0 ld half 041 rdata", bus0.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
